// File: rtl/fixed_integer_pkg.sv
// Shared types and helpers for the chunked-vector streamer.
package fixed_integer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic MODE_DATA   = 1'b0;
  localparam logic MODE_WEIGHT = 1'b1;

  // Source chunk index for a given beat. Weight beats go out in reverse order,
  // because the consumer's shift store fills top-down and must end up in index order.
  function automatic int unsigned beat_index(input logic mode, input int unsigned beat,
                                             input int unsigned beats);
    return (mode == MODE_WEIGHT) ? (beats - 1 - beat) : beat;
  endfunction

endpackage

// File: rtl/fixed_integer_vector_streamer_if.sv
// Vector-in / chunk-out bus between the layer buffer and the dot-product engines.
interface fixed_integer_vector_streamer_if #(
  parameter int BITS   = 16,
  parameter int LENGTH = 10,
  parameter int MULTS  = 2
);
  logic                              s_valid;
  logic                              s_ready;
  logic                              s_mode;
  logic [LENGTH-1:0][BITS-1:0]       s_vector;
  logic                              hold;
  logic [MULTS-1:0][BITS-1:0]        m_chunk;
  logic                              m_load_a;
  logic                              m_in_valid;
  logic                              busy;
  logic                              done;

  // Producer side: drives the vector handshake and the downstream pause.
  modport master (
    output s_valid, s_mode, s_vector, hold,
    input  s_ready, m_chunk, m_load_a, m_in_valid, busy, done
  );

  // Streamer side.
  modport slave (
    input  s_valid, s_mode, s_vector, hold,
    output s_ready, m_chunk, m_load_a, m_in_valid, busy, done
  );
endinterface

// File: rtl/fixed_integer_vector_streamer.sv
// Splits a full vector into LENGTH/MULTS beats of MULTS elements, strobed as
// weight loads or data beats, with gapless back-to-back vector acceptance.
module fixed_integer_vector_streamer
  import fixed_integer_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int LENGTH = 10,
  parameter int MULTS  = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  fixed_integer_vector_streamer_if.slave bus
);

  localparam int BEATS = LENGTH / MULTS;
  localparam int CW    = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  if (((LENGTH % MULTS) != 0) || (LENGTH < MULTS)) begin : g_bad_length
    $error("LENGTH must be a non-zero multiple of MULTS");
  end

  state_t                       r_state;
  logic [CW-1:0]                r_beat;
  logic [LENGTH-1:0][BITS-1:0]  r_buf;
  logic                         r_mode;
  logic [MULTS-1:0][BITS-1:0]   r_chunk;
  logic                         r_load_a;
  logic                         r_in_valid;
  logic                         r_done;

  logic                         w_last;
  logic                         w_ready;
  logic                         w_accept;
  logic [CW-1:0]                w_idx;
  logic [MULTS-1:0][BITS-1:0]   w_chunk;

  assign w_last   = (r_state == STREAM) && (r_beat == LAST_BEAT);
  assign w_ready  = (r_state == IDLE) || (w_last && !bus.hold);
  assign w_accept = bus.s_valid && w_ready;
  assign w_idx    = CW'(beat_index(r_mode, 32'(r_beat), BEATS));

  // Element mux: one lane per multiplier, selecting from the captured vector.
  for (genvar gi = 0; gi < MULTS; gi++) begin : g_lane
    assign w_chunk[gi] = r_buf[MULTS * int'(w_idx) + gi];
  end

  assign bus.s_ready    = w_ready;
  assign bus.busy       = (r_state == STREAM);
  assign bus.m_chunk    = r_chunk;
  assign bus.m_load_a   = r_load_a;
  assign bus.m_in_valid = r_in_valid;
  assign bus.done       = r_done;

  // Control FSM: capture, beat sequencing, and registered beat outputs.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state    <= IDLE;
      r_beat     <= '0;
      r_buf      <= '0;
      r_mode     <= MODE_DATA;
      r_chunk    <= '0;
      r_load_a   <= 1'b0;
      r_in_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_load_a   <= 1'b0;
      r_in_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_buf   <= bus.s_vector;
            r_mode  <= bus.s_mode;
            r_beat  <= '0;
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (!bus.hold) begin
            r_chunk    <= w_chunk;
            r_load_a   <= (r_mode == MODE_WEIGHT);
            r_in_valid <= (r_mode == MODE_DATA);
            if (w_last) begin
              r_done <= 1'b1;
              r_beat <= '0;
              if (w_accept) begin
                // Overlapped accept: next vector's beat 0 follows with no bubble.
                r_buf  <= bus.s_vector;
                r_mode <= bus.s_mode;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_integer_vector_streamer.sv
// Scoreboard bench for the vector streamer: the driver pushes expected beats on
// each accept, a negedge monitor pops and compares every strobed beat, and a
// behavioural consumer (shift weight store + accumulator) checks the dot product.
module tb_fixed_integer_vector_streamer;

  localparam int BITS   = 16;
  localparam int LENGTH = 10;
  localparam int MULTS  = 2;
  localparam int BEATS  = LENGTH / MULTS;

  typedef logic [LENGTH-1:0][BITS-1:0] vec_t;
  typedef logic [MULTS-1:0][BITS-1:0]  chunk_t;

  typedef struct packed {
    logic   mode;
    chunk_t chunk;
    logic   done;
  } exp_t;

  logic clk;
  logic rstn;

  fixed_integer_vector_streamer_if #(.BITS(BITS), .LENGTH(LENGTH), .MULTS(MULTS)) bus();

  fixed_integer_vector_streamer #(.BITS(BITS), .LENGTH(LENGTH), .MULTS(MULTS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass   = 0;
  exp_t   q[$];
  logic   exp_strobe  = 1'b0;
  logic   rst_pending = 1'b1;
  chunk_t last_chunk  = '0;

  // Behavioural consumer state.
  logic [BITS-1:0] store [LENGTH];
  longint          acc_sum = 0;
  longint          last_c  = -1;
  int              dcnt    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t make_seq(input int start);
    vec_t v;
    for (int k = 0; k < LENGTH; k++) v[k] = BITS'(start + k);
    return v;
  endfunction

  function automatic vec_t make_const(input int val);
    vec_t v;
    for (int k = 0; k < LENGTH; k++) v[k] = BITS'(val);
    return v;
  endfunction

  function automatic vec_t make_rand();
    vec_t v;
    for (int k = 0; k < LENGTH; k++) v[k] = BITS'($urandom);
    return v;
  endfunction

  // Reference: data beats go out in element order, weight beats in reverse beat order.
  task automatic push_expected(input logic mode, input vec_t v);
    exp_t e;
    for (int b = 0; b < BEATS; b++) begin
      int src;
      src = mode ? (BEATS - 1 - b) : b;
      for (int j = 0; j < MULTS; j++) e.chunk[j] = v[MULTS * src + j];
      e.mode = mode;
      e.done = (b == BEATS - 1);
      q.push_back(e);
    end
  endtask

  // One clock of stimulus. Called just after a posedge; returns whether the edge accepted.
  task automatic cyc(input logic v, input logic m, input vec_t vec, input logic h,
                     input logic r, output logic accepted);
    bus.s_valid  = v;
    bus.s_mode   = m;
    bus.s_vector = vec;
    bus.hold     = h;
    rstn         = r;
    @(negedge clk);
    #1;
    if (!r) begin
      check("s_ready", 64'(bus.s_ready), 64'((q.size() == 0) || (q.size() == 1 && !h)));
      check("busy", 64'(bus.busy), 64'(q.size() != 0));
    end
    accepted   = v && !r && bus.s_ready;
    exp_strobe = !r && (q.size() != 0) && !h;
    if (r) q.delete();
    else if (accepted) push_expected(m, vec);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m, input vec_t vec, input bit rand_hold, output int waits);
    logic a;
    a = 1'b0;
    waits = 0;
    while (!a && waits < 100) begin
      cyc(1'b1, m, vec, rand_hold ? ($urandom_range(0, 3) == 0) : 1'b0, 1'b0, a);
      waits++;
    end
    if (!a) check("accept_timeout", 64'(a), 64'(1));
  endtask

  task automatic idle(input int n, input bit rand_hold);
    logic a;
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'($urandom), make_rand(), rand_hold ? 1'($urandom) : 1'b0, 1'b0, a);
  endtask

  task automatic drain();
    logic a;
    int   n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, a);
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  // Monitor: compare each strobed beat against the scoreboard and model the consumer.
  always @(negedge clk) begin
    logic strobe;
    exp_t e;
    strobe = bus.m_load_a | bus.m_in_valid;
    if (rst_pending) begin
      check("rst_chunk", 64'(bus.m_chunk), 64'(0));
      check("rst_strobes", {62'd0, bus.m_load_a, bus.m_in_valid}, 64'(0));
      check("rst_done", 64'(bus.done), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(0));
      last_chunk = '0;
      acc_sum    = 0;
      dcnt       = 0;
    end else begin
      check("strobe_present", 64'(strobe), 64'(exp_strobe));
      if (strobe) begin
        check("one_strobe", 64'(bus.m_load_a & bus.m_in_valid), 64'(0));
        if (q.size() == 0) begin
          check("unexpected_beat", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          check("strobe_kind", 64'(bus.m_load_a), 64'(e.mode));
          check("chunk", 64'(bus.m_chunk), 64'(e.chunk));
          check("done", 64'(bus.done), 64'(e.done));
        end
        if (bus.m_load_a) begin
          for (int k = LENGTH - 1; k >= MULTS; k--) store[k] = store[k - MULTS];
          for (int j = 0; j < MULTS; j++) store[j] = bus.m_chunk[j];
        end else begin
          for (int j = 0; j < MULTS; j++)
            acc_sum += longint'(bus.m_chunk[j]) * longint'(store[MULTS * dcnt + j]);
          dcnt++;
          if (bus.done) begin
            last_c  = acc_sum;
            acc_sum = 0;
            dcnt    = 0;
          end
        end
        last_chunk = bus.m_chunk;
      end else begin
        check("idle_done", 64'(bus.done), 64'(0));
        check("chunk_held", 64'(bus.m_chunk), 64'(last_chunk));
      end
    end
    rst_pending = rstn;
  end

  initial begin
    logic a;
    int   w;
    for (int k = 0; k < LENGTH; k++) store[k] = '0;
    bus.s_valid = 1'b0; bus.s_mode = 1'b0; bus.s_vector = '0; bus.hold = 1'b0;
    rstn = 1'b1;
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, a);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, a);
    idle(2, 1'b1);

    // Weights 1..10, then data 1..10: c = sum k^2 = 385.
    send(1'b1, make_seq(1), 1'b0, w);
    drain();
    idle(1, 1'b0);
    send(1'b0, make_seq(1), 1'b0, w);
    drain();
    check("dot_c_sq", 64'(last_c), 64'(385));

    // Back-to-back with s_valid held: second accept lands exactly BEATS cycles later.
    send(1'b0, make_seq(1), 1'b0, w);
    send(1'b0, make_seq(11), 1'b0, w);
    check("b2b_gap", 64'(w), 64'(BEATS));
    drain();

    // Hold for 3 cycles after beat 1 of a data stream.
    send(1'b0, make_seq(1), 1'b0, w);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, a);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, a);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, a);
    drain();

    // Reset in place of beat 2, then a fresh vector.
    send(1'b0, make_seq(1), 1'b0, w);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, a);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, a);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, a);
    idle(1, 1'b1);
    send(1'b1, make_seq(21), 1'b0, w);
    drain();

    // End-to-end: weights 1..10, data all ones -> 55.
    send(1'b1, make_seq(1), 1'b0, w);
    send(1'b0, make_const(1), 1'b0, w);
    drain();
    check("dot_c_e2e", 64'(last_c), 64'(55));

    // Randomized traffic with random gaps and holds.
    for (int n = 0; n < 40; n++) begin
      send(1'($urandom), make_rand(), 1'b1, w);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), 1'b1);
    end
    drain();
    idle(2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fixed_integer_vector_streamer.md
Name: fixed_integer_vector_streamer

Overview:
- Transmit side of the chunked-vector interface used by fixed_integer_vector_dot_vector.
- Accepts one full LENGTH-element vector per valid/ready handshake.
- Emits the vector as LENGTH/MULTS beats of MULTS elements, strobed on either m_load_a (weight load) or m_in_valid (data stream).
- Sits between the layer controller/buffer and the dot-product engines.
- Performs the beat reordering needed so the consumer's shift-register weight store ends up in index order.

Parameters:
- BITS, 16, element width.
- LENGTH, 10, elements per vector. LENGTH % MULTS must be 0; elaboration-time assertion.
- MULTS, 2, elements per beat.
- Derived: BEATS = LENGTH/MULTS; CW = $clog2(BEATS)+1.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-high (rstn=1 resets on the clk edge).
- s_valid  in  1  input vector valid.
- s_ready  out  1  block can accept a vector this cycle.
- s_mode  in  1  0 = data (in_valid beats), 1 = weights (load_a beats); sampled with the vector.
- s_vector  in  [BITS-1:0] x LENGTH  input vector.
- hold  in  1  downstream pause; freezes beat progress.
- m_chunk  out  [BITS-1:0] x MULTS  current beat elements (registered).
- m_load_a  out  1  weight beat strobe (registered).
- m_in_valid  out  1  data beat strobe (registered).
- busy  out  1  STREAM state.
- done  out  1  one-cycle pulse coincident with the last beat strobe.

Behaviour:
- Reset values:
  - state=IDLE; beat=0.
  - m_chunk all 0; m_load_a, m_in_valid, done, busy = 0.
  - Capture buffer and mode register cleared to 0.
  - Reset has priority over every other event.
- States: IDLE, STREAM.
- Accept: a vector is taken on a clk edge where s_valid && s_ready. On accept:
  - s_vector and s_mode are captured.
  - beat=0; state goes to STREAM.
- s_ready (combinational) = IDLE || (STREAM && beat==BEATS-1 && !hold). This allows gapless back-to-back vectors.
- Latency: the first beat strobe is visible on the cycle after the accept edge.
- STREAM, hold=0, each cycle:
  - Register m_chunk[j] = buf[MULTS*idx + j].
  - Data mode: idx = beat.
  - Weight mode: idx = BEATS-1-beat. The consumer's shift store fills top-down, so after BEATS loads consumer slot k holds element k.
  - Assert m_load_a if mode=1, else m_in_valid. Never assert both.
  - Increment beat.
- Last beat (beat==BEATS-1, hold=0):
  - done=1 with that strobe.
  - If a new vector is accepted on the same edge, stay in STREAM with beat=0 and the new buffer/mode. The next cycle emits the new vector's beat 0 with no bubble.
  - Otherwise return to IDLE.
- hold=1 in STREAM:
  - Strobes and done are 0 next cycle.
  - m_chunk, beat and the buffer hold their values.
  - s_ready=0.
- hold in IDLE has no effect.
- IDLE: strobes and done are 0; m_chunk holds its last value.
- s_mode, s_vector and s_valid are ignored when s_ready=0. No capture occurs during STREAM except at the last-beat overlap.
- Counter: beat is CW bits and never exceeds BEATS-1. BEATS=1 is legal; every stream is then a single beat with done on it.
- No arithmetic; element data is passed bit-exact.

Decomposition:
- Shared package fixed_integer_pkg holds:
  - state enum typedef (IDLE, STREAM);
  - MODE_DATA=0 and MODE_WEIGHT=1 constants;
  - a beat_index function (mode, beat, BEATS) returning idx.
- Single module, no sub-module. The mux is a generate loop over MULTS indexed by idx.

Test Plan (BITS=16, LENGTH=10, MULTS=2, BEATS=5):
- Weights, s_vector=1..10, s_mode=1:
  - m_load_a high 5 consecutive cycles starting the cycle after accept.
  - m_chunk sequence {9,10},{7,8},{5,6},{3,4},{1,2}; done on the 5th beat.
  - m_in_valid stays 0.
- Data, s_vector=1..10, s_mode=0:
  - m_in_valid 5 cycles; m_chunk {1,2},{3,4},{5,6},{7,8},{9,10}.
  - s_ready low during beats 0-3.
- Back-to-back: vectors 1..10 then 11..20, s_valid held high:
  - 10 contiguous strobe cycles with no gap.
  - Second accept on the first vector's last-beat edge.
  - m_chunk {11,12} immediately follows {9,10}.
- hold=1 for 3 cycles after beat 1 of the data stream:
  - Strobes 0 for 3 cycles; m_chunk stays {3,4}.
  - Then beats 2-4 resume; 8 cycles total from first to last strobe.
- rstn=1 during beat 2:
  - Next cycle all outputs 0 and state IDLE; s_ready=1.
  - A fresh vector then streams correctly from beat 0.
- End-to-end with fixed_integer_vector_dot_vector:
  - Load weights 1..10, then stream data all 1s.
  - Consumer output c = 55.
